// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM controller slice.
package dram_pkg;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = ROW_W + COL_W;

    // Default cycle-level timing for the attached DRAM.
    localparam int DEF_T_ASR        = 1;
    localparam int DEF_T_RAH        = 1;
    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_CAS        = 3;
    localparam int DEF_T_RAS        = 5;
    localparam int DEF_T_RP         = 3;
    localparam int DEF_T_CSR        = 1;
    localparam int DEF_T_CHR        = 2;
    localparam int DEF_REF_INTERVAL = 1500;

    typedef enum logic [2:0] {
        IDLE, ROW, RAS, CAS, PRE, RCSR, RHLD, RRAS
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_ref_timer.sv
// Refresh interval counter: raises ref_pending every REF_INTERVAL cycles and
// flags an overrun when an interval expires before the previous one was serviced.
module dram_ref_timer #(
    parameter int REF_INTERVAL = 1500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic ref_pending,
    output logic ref_overrun
);
    localparam int CW = $clog2(REF_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == '0);

    // Free-running down-counter; expiry wins over a same-cycle clear because
    // it marks the start of a fresh interval that still needs its own refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= RELOAD;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            cnt <= expire ? RELOAD : cnt - 1'b1;
            if (expire)
                ref_pending <= 1'b1;
            else if (clr)
                ref_pending <= 1'b0;
            if (expire && ref_pending && !clr)
                ref_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// Cycle-level DRAM controller: word/byte accesses over valid/ready with
// autonomous CAS-before-RAS refresh. All DRAM-facing outputs are registered.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int T_ASR        = DEF_T_ASR,
    parameter int T_RAH        = DEF_T_RAH,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CAS        = DEF_T_CAS,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CSR        = DEF_T_CSR,
    parameter int T_CHR        = DEF_T_CHR,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ref_overrun,
    output logic [ROW_W-1:0]  ma,
    output logic              ras_n,
    output logic              cas_n,
    output logic              uwe_n,
    output logic              lwe_n,
    output logic              oe_n,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_i
);
    localparam int T_MAX = max2(max2(max2(T_ASR, T_RCD), max2(T_CAS, T_RAS)),
                                max2(max2(T_RP, T_CSR), T_CHR));
    localparam int TW    = $clog2(T_MAX) + 1;

    state_t              state;
    logic [TW-1:0]       tmr;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic                we_q;
    logic [1:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                idle_q;
    logic                ref_pending;
    logic                ref_start;

    // idle_q lags reset by one edge so ready stays low while rst_n is held.
    assign req_ready = idle_q && !ref_pending;
    assign ref_start = (state == IDLE) && ref_pending;

    dram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (ref_start),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    // Access/refresh sequencer; each branch sets the strobes for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            wdata_q   <= '0;
            idle_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ma        <= '0;
            ras_n     <= 1'b1;
            cas_n     <= 1'b1;
            uwe_n     <= 1'b1;
            lwe_n     <= 1'b1;
            oe_n      <= 1'b1;
            dq_o      <= '0;
            dq_oe     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        row_q   <= req_addr[ADDR_W-1:COL_W];
                        col_q   <= req_addr[COL_W-1:0];
                        we_q    <= req_we;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        ma      <= req_addr[ADDR_W-1:COL_W];
                        idle_q  <= 1'b0;
                        tmr     <= TW'(T_ASR - 1);
                        state   <= ROW;
                    end else if (ref_pending) begin
                        cas_n  <= 1'b0;
                        idle_q <= 1'b0;
                        tmr    <= TW'(T_CSR - 1);
                        state  <= RCSR;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                ROW: begin
                    if (tmr == '0) begin
                        ras_n <= 1'b0;
                        tmr   <= TW'(T_RCD - 1);
                        state <= RAS;
                        if (T_RAH == 0) begin
                            ma <= ROW_W'(col_q);
                            if (we_q) begin
                                uwe_n <= ~be_q[1];
                                lwe_n <= ~be_q[0];
                                dq_o  <= wdata_q;
                                dq_oe <= 1'b1;
                            end
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RAS: begin
                    if (tmr == '0) begin
                        cas_n <= 1'b0;
                        ma    <= ROW_W'(col_q);
                        tmr   <= TW'(T_CAS - 1);
                        state <= CAS;
                        if (!we_q)
                            oe_n <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                        // Row hold satisfied: switch to column and start early write.
                        if (tmr <= TW'(T_RCD - T_RAH)) begin
                            ma <= ROW_W'(col_q);
                            if (we_q) begin
                                uwe_n <= ~be_q[1];
                                lwe_n <= ~be_q[0];
                                dq_o  <= wdata_q;
                                dq_oe <= 1'b1;
                            end
                        end
                    end
                end
                CAS: begin
                    if (tmr == '0) begin
                        ras_n <= 1'b1;
                        cas_n <= 1'b1;
                        uwe_n <= 1'b1;
                        lwe_n <= 1'b1;
                        oe_n  <= 1'b1;
                        dq_oe <= 1'b0;
                        ma    <= '0;
                        tmr   <= TW'(T_RP - 1);
                        state <= PRE;
                        if (!we_q) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= dq_i;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                PRE: begin
                    if (tmr == '0) begin
                        idle_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RCSR: begin
                    if (tmr == '0) begin
                        ras_n <= 1'b0;
                        tmr   <= TW'(T_CHR - 1);
                        state <= RHLD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RHLD: begin
                    if (tmr == '0) begin
                        cas_n <= 1'b1;
                        tmr   <= TW'(T_RAS - T_CHR - 1);
                        state <= RRAS;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                RRAS: begin
                    if (tmr == '0) begin
                        ras_n <= 1'b1;
                        tmr   <= TW'(T_RP - 1);
                        state <= PRE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
